// File: rtl/pipe_sub_pkg.sv
// Shared types and the 4-bit borrow-lookahead kernel for the pipelined subtractor.
// The stage record is sized for PIPE_NSLICE slices; the top's NSLICE must match it.
package pipe_sub_pkg;

  localparam int unsigned SLICE_W     = 4;
  localparam int unsigned PIPE_NSLICE = 4;
  localparam int unsigned PIPE_W      = SLICE_W * PIPE_NSLICE;

  typedef struct packed {
    logic              valid;
    logic [PIPE_W-1:0] diff_done;
    logic [PIPE_W-1:0] a_rem;
    logic [PIPE_W-1:0] b_rem;
    logic              borrow;
    logic              sign_a;
    logic              sign_b;
  } stage_t;

  // Returns {d[3:0], bout}; every borrow is a flat sum of products, nothing ripples.
  function automatic logic [SLICE_W:0] slice_sub(
    input logic [SLICE_W-1:0] a,
    input logic [SLICE_W-1:0] b,
    input logic               bin
  );
    logic [SLICE_W-1:0] g;
    logic [SLICE_W-1:0] p;
    logic [SLICE_W:1]   c;
    g    = ~a & b;
    p    = ~(a ^ b);
    c[1] = g[0] | (p[0] & bin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & bin);
    return {a ^ b ^ {c[3:1], bin}, c[4]};
  endfunction

endpackage

// File: rtl/pipelined_cla_subtractor_bla4_slice.sv
// Combinational 4-bit borrow-lookahead slice: d = a - b - bin, bout = slice borrow-out.
module bla4_slice
  import pipe_sub_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               bin,
  output logic [SLICE_W-1:0] d,
  output logic               bout
);

  logic [SLICE_W:0] res;

  assign res  = slice_sub(a, b, bin);
  assign d    = res[SLICE_W:1];
  assign bout = res[0];

endmodule

// File: rtl/pipelined_cla_subtractor.sv
// Pipelined WIDTH-bit subtractor, one borrow-lookahead slice per stage, valid/ready stream.
// Optional ovf/zero flag ports are built when PIPE_SUB_FLAGS_EN is defined.
module pipelined_cla_subtractor
  import pipe_sub_pkg::*;
#(
  parameter  int unsigned NSLICE = PIPE_NSLICE,
  localparam int unsigned WIDTH  = SLICE_W * NSLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef PIPE_SUB_FLAGS_EN
  ,
  output logic             ovf,
  output logic             zero
`endif
);

  stage_t st [NSLICE];
  logic   adv;
  logic   unused;

  assign adv      = ~st[NSLICE-1].valid | out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < NSLICE; k++) begin : g_stage
    stage_t             prv;
    stage_t             nxt;
    logic [SLICE_W-1:0] sd;
    logic               sbout;

    if (k == 0) begin : g_head
      // adv doubles as in_ready, so in_valid alone is the accepted-beat flag here.
      always_comb begin
        prv        = '0;
        prv.valid  = in_valid;
        prv.a_rem  = a;
        prv.b_rem  = b;
        prv.borrow = borrow_in;
`ifdef PIPE_SUB_FLAGS_EN
        prv.sign_a = a[WIDTH-1];
        prv.sign_b = b[WIDTH-1];
`endif
      end
    end else begin : g_body
      assign prv = st[k-1];
    end

    bla4_slice u_slice (
      .a    (prv.a_rem[SLICE_W*k +: SLICE_W]),
      .b    (prv.b_rem[SLICE_W*k +: SLICE_W]),
      .bin  (prv.borrow),
      .d    (sd),
      .bout (sbout)
    );

    always_comb begin
      nxt                                   = prv;
      nxt.diff_done[SLICE_W*k +: SLICE_W] = sd;
      nxt.borrow                            = sbout;
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        st[k] <= '0;
      end else if (adv) begin
        st[k] <= nxt;
      end
    end
  end

  assign out_valid  = st[NSLICE-1].valid;
  assign diff       = st[NSLICE-1].diff_done;
  assign borrow_out = st[NSLICE-1].borrow;

`ifdef PIPE_SUB_FLAGS_EN
  assign ovf    = (st[NSLICE-1].sign_a ^ st[NSLICE-1].sign_b) & (diff[WIDTH-1] ^ st[NSLICE-1].sign_a);
  // Gated by out_valid so the reset-cleared diff does not report zero.
  assign zero   = out_valid & ~|diff;
  assign unused = ^{st[NSLICE-1].a_rem, st[NSLICE-1].b_rem};
`else
  assign unused = ^{st[NSLICE-1].a_rem, st[NSLICE-1].b_rem,
                    st[NSLICE-1].sign_a, st[NSLICE-1].sign_b};
`endif

endmodule

// File: tb/tb_pipelined_cla_subtractor.sv
// Self-checking bench for pipelined_cla_subtractor: directed vectors, streaming, stall, reset, random.
module tb_pipelined_cla_subtractor;

  localparam int unsigned NSLICE = 4;
  localparam int unsigned W      = 4 * NSLICE;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         borrow_in = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] diff;
  logic         borrow_out;
`ifdef PIPE_SUB_FLAGS_EN
  logic         ovf;
  logic         zero;
`endif

  always #5 clk = ~clk;

  pipelined_cla_subtractor #(.NSLICE(NSLICE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .borrow_in  (borrow_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef PIPE_SUB_FLAGS_EN
    ,
    .ovf        (ovf),
    .zero       (zero)
`endif
  );

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
    logic         z;
  } res_t;

  res_t sb [$];
  int   checks = 0;
  int   failures = 0;

  logic         o_valid, o_ready, o_bo, o_ov, o_z, acc, drn;
  logic [W-1:0] o_diff;

  // Plain integer arithmetic: unsigned result for diff/borrow, signed range test for overflow.
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bin);
    res_t r;
    int   du, ds, sx, sy;
    du   = int'(x) - int'(y) - int'(bin);
    r.d  = du[W-1:0];
    r.bo = (du < 0);
    sx   = int'($signed(x));
    sy   = int'($signed(y));
    ds   = sx - sy - int'(bin);
    r.ov = (ds > (2**(W-1)) - 1) || (ds < -(2**(W-1)));
    r.z  = (r.d == '0);
`ifndef PIPE_SUB_FLAGS_EN
    r.ov = 1'b0;
    r.z  = 1'b0;
`endif
    return r;
  endfunction

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = '1;
      2:       v = {1'b1, {(W-1){1'b0}}};
      3:       v = {1'b0, {(W-1){1'b1}}};
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  // Drive one cycle at the falling edge, sample just after, record the handshake outcome.
  task automatic step(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic bin, input logic ordy);
    in_valid  = v;
    a         = x;
    b         = y;
    borrow_in = bin;
    out_ready = ordy;
    #1;
    o_valid = out_valid;
    o_ready = in_ready;
    o_diff  = diff;
    o_bo    = borrow_out;
`ifdef PIPE_SUB_FLAGS_EN
    o_ov    = ovf;
    o_z     = zero;
`else
    o_ov    = 1'b0;
    o_z     = 1'b0;
`endif
    acc = in_valid & in_ready;
    drn = out_valid & out_ready;
    if (acc) sb.push_back(model(x, y, bin));
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step(1'b0, '0, '0, 1'b0, 1'b0);
    checks++;
    if ({o_valid, o_diff, o_bo} !== {1'b0, {W{1'b0}}, 1'b0}) begin
      failures++;
      $display("FAIL reset_outputs got valid=%b diff=%h bo=%b, expected 0 0000 0", o_valid, o_diff, o_bo);
    end
`ifdef PIPE_SUB_FLAGS_EN
    checks++;
    if ({o_ov, o_z} !== 2'b00) begin
      failures++;
      $display("FAIL reset_flags got ovf=%b zero=%b, expected 0 0", o_ov, o_z);
    end
`endif
    rst_n = 1'b1;
    step(1'b0, '0, '0, 1'b0, 1'b0);
    checks++;
    if (o_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got %b, expected 1", o_ready);
    end
    sb.delete();
  endtask

  task automatic test_directed();
    logic [W-1:0] va  [5] = '{16'h1234, 16'h0000, 16'h8000, 16'h5555, 16'h7FFF};
    logic [W-1:0] vb  [5] = '{16'h0234, 16'h0001, 16'h0000, 16'h5555, 16'hFFFF};
    logic         vbi [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [W-1:0] ed  [5] = '{16'h1000, 16'hFFFF, 16'h7FFF, 16'h0000, 16'h8000};
    logic         ebo [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic         eov [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic         ez  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      int lat;
      lat = -1;
      step(1'b1, va[i], vb[i], vbi[i], 1'b1);
      for (int c = 1; c <= 20 && lat < 0; c++) begin
        step(1'b0, '0, '0, 1'b0, 1'b1);
        if (o_valid) lat = c;
      end
      checks++;
      if (lat != int'(NSLICE)) begin
        failures++;
        $display("FAIL directed_latency vec=%0d got %0d cycles, expected %0d", i, lat, NSLICE);
      end
      checks++;
      if ({o_diff, o_bo} !== {ed[i], ebo[i]}) begin
        failures++;
        $display("FAIL directed_result vec=%0d got diff=%h bo=%b, expected diff=%h bo=%b",
                 i, o_diff, o_bo, ed[i], ebo[i]);
      end
`ifdef PIPE_SUB_FLAGS_EN
      checks++;
      if ({o_ov, o_z} !== {eov[i], ez[i]}) begin
        failures++;
        $display("FAIL directed_flags vec=%0d got ovf=%b zero=%b, expected ovf=%b zero=%b",
                 i, o_ov, o_z, eov[i], ez[i]);
      end
`else
      if (eov[i] === 1'bx || ez[i] === 1'bx) $display("note: flag table entry undefined");
`endif
    end
    sb.delete();
  endtask

  task automatic test_back_to_back();
    int   sent, ndrain, first, last;
    res_t e;
    sent = 0; ndrain = 0; first = -1; last = -1;
    for (int c = 0; c < 40 && (sent < 8 || sb.size() > 0); c++) begin
      if (sent < 8) step(1'b1, pick(), pick(), 1'($urandom), 1'b1);
      else          step(1'b0, '0, '0, 1'b0, 1'b1);
      if (acc) sent++;
      if (drn) begin
        ndrain++;
        if (first < 0) first = c;
        last = c;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL b2b_extra got diff=%h with no result outstanding", o_diff);
        end else begin
          e = sb.pop_front();
          if ({o_diff, o_bo, o_ov, o_z} !== {e.d, e.bo, e.ov, e.z}) begin
            failures++;
            $display("FAIL b2b_result got diff=%h bo=%b ovf=%b zero=%b, expected diff=%h bo=%b ovf=%b zero=%b",
                     o_diff, o_bo, o_ov, o_z, e.d, e.bo, e.ov, e.z);
          end
        end
      end
    end
    checks++;
    if (ndrain != 8 || last - first + 1 != 8 || sent != 8) begin
      failures++;
      $display("FAIL b2b_run got sent=%0d drained=%0d span=%0d, expected 8 8 8",
               sent, ndrain, last - first + 1);
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] pa, pb;
    logic         pbi;
    int           sent, ndrain;
    res_t         e;
    pa = pick(); pb = pick(); pbi = 1'($urandom);
    sent = 0; ndrain = 0;
    o_valid = 1'b0;
    for (int c = 0; c < 12 && !o_valid; c++) begin
      step(1'b1, pa, pb, pbi, 1'b0);
      if (acc) begin
        sent++;
        pa = pick(); pb = pick(); pbi = 1'($urandom);
      end
    end
    checks++;
    if (!o_valid || sent != int'(NSLICE)) begin
      failures++;
      $display("FAIL stall_fill got valid=%b accepted=%0d, expected 1 %0d", o_valid, sent, NSLICE);
    end
    for (int c = 0; c < 5; c++) begin
      step(1'b1, pa, pb, pbi, 1'b0);
      checks++;
      if (o_ready !== 1'b0 || acc) begin
        failures++;
        $display("FAIL stall_in_ready cycle=%0d got in_ready=%b, expected 0", c, o_ready);
      end
      checks++;
      if (sb.size() == 0 ||
          {o_valid, o_diff, o_bo, o_ov, o_z} !== {1'b1, sb[0].d, sb[0].bo, sb[0].ov, sb[0].z}) begin
        failures++;
        $display("FAIL stall_hold cycle=%0d got valid=%b diff=%h bo=%b, expected head result held",
                 c, o_valid, o_diff, o_bo);
      end
    end
    for (int c = 0; c < 40 && (sent < 6 || sb.size() > 0); c++) begin
      if (sent < 6) step(1'b1, pa, pb, pbi, 1'b1);
      else          step(1'b0, '0, '0, 1'b0, 1'b1);
      if (acc) begin
        sent++;
        pa = pick(); pb = pick(); pbi = 1'($urandom);
      end
      if (drn) begin
        ndrain++;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL stall_extra got diff=%h with no result outstanding", o_diff);
        end else begin
          e = sb.pop_front();
          if ({o_diff, o_bo, o_ov, o_z} !== {e.d, e.bo, e.ov, e.z}) begin
            failures++;
            $display("FAIL stall_result got diff=%h bo=%b ovf=%b zero=%b, expected diff=%h bo=%b ovf=%b zero=%b",
                     o_diff, o_bo, o_ov, o_z, e.d, e.bo, e.ov, e.z);
          end
        end
      end
    end
    checks++;
    if (ndrain != 6 || sb.size() != 0) begin
      failures++;
      $display("FAIL stall_count got drained=%0d outstanding=%0d, expected 6 0", ndrain, sb.size());
    end
  endtask

  task automatic test_reset_midflight();
    int   got;
    res_t e;
    repeat (3) step(1'b1, pick(), pick(), 1'($urandom), 1'b1);
    rst_n = 1'b0;
    step(1'b0, '0, '0, 1'b0, 1'b1);
    rst_n = 1'b1;
    sb.delete();
    for (int c = 0; c < 4; c++) begin
      step(1'b0, '0, '0, 1'b0, 1'b1);
      checks++;
      if (o_valid !== 1'b0) begin
        failures++;
        $display("FAIL rstmid_valid cycle=%0d got out_valid=%b, expected 0", c, o_valid);
      end
    end
    step(1'b1, 16'hA5C3, 16'h5A3C, 1'b1, 1'b1);
    got = 0;
    for (int c = 0; c < 20 && got == 0; c++) begin
      step(1'b0, '0, '0, 1'b0, 1'b1);
      if (drn) begin
        got = 1;
        e = sb.pop_front();
        checks++;
        if ({o_diff, o_bo, o_ov, o_z} !== {e.d, e.bo, e.ov, e.z}) begin
          failures++;
          $display("FAIL rstmid_result got diff=%h bo=%b, expected diff=%h bo=%b", o_diff, o_bo, e.d, e.bo);
        end
      end
    end
    checks++;
    if (got == 0 || sb.size() != 0) begin
      failures++;
      $display("FAIL rstmid_fresh got results=%0d outstanding=%0d, expected 1 0", got, sb.size());
    end
  endtask

  task automatic test_random();
    logic [W-1:0] pa, pb;
    logic         pbi, pv, ordy;
    res_t         e;
    pv = 1'b0; pa = '0; pb = '0; pbi = 1'b0;
    for (int c = 0; c < 300 && (c < 100 || pv || sb.size() > 0); c++) begin
      if (!pv && c < 100 && $urandom_range(0, 3) != 0) begin
        pv = 1'b1; pa = pick(); pb = pick(); pbi = 1'($urandom);
      end
      ordy = (c >= 100) || ($urandom_range(0, 3) != 0);
      step(pv, pa, pb, pbi, ordy);
      if (acc) pv = 1'b0;
      if (drn) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL random_extra got diff=%h with no result outstanding", o_diff);
        end else begin
          e = sb.pop_front();
          if ({o_diff, o_bo, o_ov, o_z} !== {e.d, e.bo, e.ov, e.z}) begin
            failures++;
            $display("FAIL random_result got diff=%h bo=%b ovf=%b zero=%b, expected diff=%h bo=%b ovf=%b zero=%b",
                     o_diff, o_bo, o_ov, o_z, e.d, e.bo, e.ov, e.z);
          end
        end
      end
    end
    checks++;
    if (sb.size() != 0 || pv) begin
      failures++;
      $display("FAIL random_drain got outstanding=%0d pending=%b, expected 0 0", sb.size(), pv);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
